reset_seq: RTL and testbench
============================

RESET_SEQ -- requirements
Module: reset_seq

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2: count of asynchronous reset request inputs.
REQ-002 SHALL have parameter NUM_OUT, default 4: count of reset output channels; must be at least 1.
REQ-003 SHALL have parameter MIN_RESET_CYCLES, default 3: request-free cycles before the first release; must be at least 1.
REQ-004 SHALL have parameter STAGE_GAP, default 2: cycles between successive channel releases; must be at least 1.
REQ-005 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for req_i; must be at least 2.
REQ-006 SHALL have port clk, input, 1 bit: single clock.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-008 SHALL have port req_i, input, NUM_SRC bits: asynchronous active-high reset requests.
REQ-009 SHALL have port sw_req_i, input, 1 bit: synchronous active-high software reset request.
REQ-010 SHALL have port cause_clr_i, input, 1 bit: synchronous clear of the cause register.
REQ-011 SHALL have port rst_o, output, NUM_OUT bits: active-high per-channel resets, released in index order.
REQ-012 SHALL have port done_o, output, 1 bit: high when every channel is released.
REQ-013 SHALL have port cause_o, output, NUM_SRC+2 bits: sticky reset-cause flags.

Function
REQ-014 SHALL pass each req_i bit through its own SYNC_STAGES synchronizer, reset to 0, before any use.
REQ-015 SHALL implement FSM states HOLD, RELEASE and RUN.
REQ-016 SHALL define "request" as: any synchronized req_i bit high, or sw_req_i high.
REQ-017 In HOLD, SHALL clear the cycle counter on a request and otherwise increment it.
REQ-018 SHALL deassert rst_o[0] and enter RELEASE on the MIN_RESET_CYCLES-th consecutive request-free edge in HOLD.
REQ-019 In RELEASE, SHALL deassert rst_o[k] exactly STAGE_GAP edges after rst_o[k-1].
REQ-020 SHALL raise done_o and enter RUN on the same edge that rst_o[NUM_OUT-1] deasserts.
REQ-021 If NUM_OUT=1, SHALL go from HOLD directly to RUN when rst_o[0] deasserts.
REQ-022 On a request in RELEASE or RUN, SHALL on the next edge assert all rst_o, clear done_o and the counter, and enter HOLD.
REQ-023 SHALL assert rst_o one edge after sw_req_i, and SYNC_STAGES+1 edges after a req_i rising edge.
REQ-024 SHALL drive all outputs from flops, with no combinational path from any input to rst_o or done_o.
REQ-025 Channel release SHALL be monotonic: rst_o[k] is never low while rst_o[j] is high for any j<k.
REQ-026 SHALL size the counter to ceil(log2(max(MIN_RESET_CYCLES,STAGE_GAP)+1)) bits, with no wrap in any state.

Reset
REQ-027 While rst is high, SHALL hold rst_o all ones, done_o 0, state HOLD, counter 0 and synchronizers 0.
REQ-028 After rst falls with no requests, rst_o[k] SHALL fall on edge MIN_RESET_CYCLES + k*STAGE_GAP.
REQ-029 rst asserted mid-RELEASE or mid-RUN SHALL immediately and asynchronously force the state in REQ-027.

Configuration
REQ-030 Macro RESET_SEQ_CAUSE_EN defined: cause_o SHALL be a sticky register.
  - bit0 = power-on, set by rst.
  - bit1 = software, set when sw_req_i causes entry to HOLD.
  - bit 2+i = req_i[i], set when that source causes entry to HOLD.
REQ-031 With RESET_SEQ_CAUSE_EN, cause_clr_i SHALL clear all cause bits, with a same-cycle set winning over clear.
REQ-032 Without RESET_SEQ_CAUSE_EN, cause_o SHALL be constant 0, cause_clr_i ignored and no cause flops built.

Structure
REQ-033 Package rst_seq_pkg SHALL hold the FSM state enum and the cause bit-index constants (CAUSE_POR, CAUSE_SW, CAUSE_SRC_BASE).
REQ-034 SHALL instantiate the existing sync module per req_i bit with STAGES=SYNC_STAGES; no other sub-module.

Verification (defaults: NUM_SRC=2, NUM_OUT=4, MIN=3, GAP=2, SYNC=2)
REQ-035 Release rst, no requests -> rst_o goes 1111->1110@3->1100@5->1000@7->0000@9; done_o=1@9; cause_o=0001 (with macro).
REQ-036 sw_req_i pulse for 1 cycle in RUN -> rst_o=1111 next edge; done_o=0; re-release 3 edges after the pulse ends; cause_o bit1 set.
REQ-037 req_i[1] high 5 cycles while rst_o=1100 -> all rst_o=1111 at edge 3 after assertion; release sequence restarts 3 edges after synchronized deassertion; cause bit3 set.
REQ-038 rst pulsed in RUN (done_o=1) -> rst_o=1111 and done_o=0 asynchronously, before the next clk edge; REQ-035 timing repeats.
REQ-039 cause_clr_i and sw_req_i asserted on the same edge -> cause_o=0010; cause_clr_i alone -> cause_o=0000; without macro -> cause_o always 0000.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer.
// FSM state encoding and cause-register bit positions.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_e;

  localparam int CAUSE_POR      = 0;
  localparam int CAUSE_SW       = 1;
  localparam int CAUSE_SRC_BASE = 2;

  function automatic int cnt_width(
    input int min_c,
    input int gap
  );
    int m;
    m = (min_c > gap) ? min_c : gap;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync.sv
// Multi-flop synchronizer for a single asynchronous bit.
// Flops clear to 0 on rst.
module sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/reset_seq.sv
// Staged reset sequencer with synchronized reset requests.
// Define RESET_SEQ_CAUSE_EN to build the sticky cause register.
module reset_seq
  import rst_seq_pkg::*;
#(
  parameter int NUM_SRC          = 2,
  parameter int NUM_OUT          = 4,
  parameter int MIN_RESET_CYCLES = 3,
  parameter int STAGE_GAP        = 2,
  parameter int SYNC_STAGES      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] req_i,
  input  logic               sw_req_i,
  input  logic               cause_clr_i,
  output logic [NUM_OUT-1:0] rst_o,
  output logic               done_o,
  output logic [NUM_SRC+1:0] cause_o
);

  localparam int CW = cnt_width(MIN_RESET_CYCLES, STAGE_GAP);
  localparam logic [CW-1:0] MIN_LAST = CW'(MIN_RESET_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(STAGE_GAP - 1);
  localparam logic [NUM_OUT-1:0] LAST_CH = NUM_OUT'(1) << (NUM_OUT - 1);

  logic [NUM_SRC-1:0] req_s;
  logic               req;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_sync
    sync #(
      .STAGES(SYNC_STAGES)
    ) u_sync (
      .clk(clk),
      .rst(rst),
      .d_i(req_i[i]),
      .q_o(req_s[i])
    );
  end

  assign req = (|req_s) | sw_req_i;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_OUT-1:0] rst_o_q, rst_o_d;
  logic               done_q, done_d;
  logic               enter_hold;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rst_o_d    = rst_o_q;
    done_d     = done_q;
    enter_hold = 1'b0;
    unique case (state_q)
      HOLD: begin
        if (req) begin
          cnt_d = '0;
        end else if (cnt_q == MIN_LAST) begin
          cnt_d   = '0;
          rst_o_d = rst_o_q << 1;
          if (NUM_OUT == 1) begin
            state_d = RUN;
            done_d  = 1'b1;
          end else begin
            state_d = RELEASE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RELEASE: begin
        if (req) begin
          enter_hold = 1'b1;
        end else if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          rst_o_d = rst_o_q << 1;
          if (rst_o_q == LAST_CH) begin
            state_d = RUN;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RUN: begin
        if (req) enter_hold = 1'b1;
      end
      default: begin
        enter_hold = 1'b1;
      end
    endcase
    if (enter_hold) begin
      state_d = HOLD;
      cnt_d   = '0;
      rst_o_d = '1;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      rst_o_q <= '1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_o_q <= rst_o_d;
      done_q  <= done_d;
    end
  end

  assign rst_o  = rst_o_q;
  assign done_o = done_q;

`ifdef RESET_SEQ_CAUSE_EN
  localparam logic [NUM_SRC+1:0] CAUSE_RST = (NUM_SRC + 2)'(1) << CAUSE_POR;

  logic [NUM_SRC+1:0] cause_q, cause_d;

  // Sets are applied after the clear so a same-cycle set survives.
  always_comb begin
    cause_d = cause_clr_i ? '0 : cause_q;
    if (enter_hold) begin
      if (sw_req_i) cause_d[CAUSE_SW] = 1'b1;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (req_s[i]) cause_d[CAUSE_SRC_BASE + i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cause_q <= CAUSE_RST;
    else     cause_q <= cause_d;
  end

  assign cause_o = cause_q;
`else
  logic unused_cause_clr;
  assign unused_cause_clr = cause_clr_i;
  assign cause_o = '0;
`endif

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq with an expected-value queue.
// Cause expectations follow RESET_SEQ_CAUSE_EN.
module tb_reset_seq;

  localparam int NS  = 2;
  localparam int NO  = 4;
  localparam int MIN = 3;
  localparam int GAP = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NS-1:0] req_i = '0;
  logic          sw_req_i = 1'b0;
  logic          cause_clr_i = 1'b0;
  logic [NO-1:0] rst_o;
  logic          done_o;
  logic [NS+1:0] cause_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string         tag;
    logic [NO-1:0] r;
    logic          d;
    logic [NS+1:0] c;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  reset_seq #(
    .NUM_SRC(NS),
    .NUM_OUT(NO),
    .MIN_RESET_CYCLES(MIN),
    .STAGE_GAP(GAP),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_i(req_i),
    .sw_req_i(sw_req_i),
    .cause_clr_i(cause_clr_i),
    .rst_o(rst_o),
    .done_o(done_o),
    .cause_o(cause_o)
  );

  function automatic logic [NS+1:0] cz(input logic [NS+1:0] v);
`ifdef RESET_SEQ_CAUSE_EN
    return v;
`else
    return '0 & v;
`endif
  endfunction

  function automatic int rel_k(input int n);
    int k;
    k = (n < MIN) ? 0 : ((n - MIN) / GAP + 1);
    if (k > NO) k = NO;
    return k;
  endfunction

  function automatic logic [NO-1:0] rel_r(input int n);
    logic [NO-1:0] ones;
    ones = '1;
    return ones << rel_k(n);
  endfunction

  task automatic push(
    input string         t,
    input logic [NO-1:0] r,
    input logic          d,
    input logic [NS+1:0] c
  );
    exp_t e;
    e.tag = t;
    e.r = r;
    e.d = d;
    e.c = c;
    sb.push_back(e);
  endtask

  task automatic push_rel(input string t, input logic [NS+1:0] c);
    for (int n = 1; n <= 9; n++) begin
      push($sformatf("%s_e%0d", t, n), rel_r(n), rel_k(n) == NO, c);
    end
  endtask

  task automatic check_now();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL sb_empty: got no expected entry, required one");
    end else begin
      e = sb.pop_front();
      assert ({rst_o, done_o, cause_o} === {e.r, e.d, e.c})
      else begin
        failures++;
        $error("FAIL %s: got rst_o=%b done_o=%b cause_o=%b, required rst_o=%b done_o=%b cause_o=%b",
               e.tag, rst_o, done_o, cause_o, e.r, e.d, e.c);
      end
    end
  endtask

  task automatic step_check();
    @(posedge clk);
    @(negedge clk);
    check_now();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step_check();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    push("reset_state", 4'b1111, 1'b0, cz(4'b0001));
    check_now();
    rst = 1'b0;
    push_rel("por", cz(4'b0001));
    push("por_run", 4'b0000, 1'b1, cz(4'b0001));
    drain(10);

    sw_req_i = 1'b1;
    push("sw_assert", 4'b1111, 1'b0, cz(4'b0011));
    step_check();
    sw_req_i = 1'b0;
    push_rel("sw_rel", cz(4'b0011));
    drain(9);

    cause_clr_i = 1'b1;
    push("clr_alone", 4'b0000, 1'b1, 4'b0000);
    step_check();
    cause_clr_i = 1'b0;

    sw_req_i = 1'b1;
    push("sw2_assert", 4'b1111, 1'b0, cz(4'b0010));
    step_check();
    sw_req_i = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      push($sformatf("sw2_e%0d", n), rel_r(n), 1'b0, cz(4'b0010));
    end
    drain(5);

    req_i = 2'b10;
    push("req_f1", 4'b1100, 1'b0, cz(4'b0010));
    push("req_f2", 4'b1000, 1'b0, cz(4'b0010));
    push("req_f3", 4'b1111, 1'b0, cz(4'b1010));
    push("req_f4", 4'b1111, 1'b0, cz(4'b1010));
    push("req_f5", 4'b1111, 1'b0, cz(4'b1010));
    drain(5);
    req_i = 2'b00;
    push("req_f6", 4'b1111, 1'b0, cz(4'b1010));
    push("req_f7", 4'b1111, 1'b0, cz(4'b1010));
    push_rel("req_rel", cz(4'b1010));
    drain(11);

    cause_clr_i = 1'b1;
    sw_req_i = 1'b1;
    push("clr_sw", 4'b1111, 1'b0, cz(4'b0010));
    step_check();
    cause_clr_i = 1'b0;
    sw_req_i = 1'b0;
    push_rel("clr_sw_rel", cz(4'b0010));
    drain(9);

    #2 rst = 1'b1;
    #1 push("async_rst", 4'b1111, 1'b0, cz(4'b0001));
    check_now();
    #1 rst = 1'b0;
    push_rel("por2", cz(4'b0001));
    drain(9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
